// File: rtl/cla8_pipe_if.sv
// rtl/cla8_pipe_if.sv - operand/result handshake bundle for cla8_pipe (out_ovf only with CLA8_OVF_EN)
interface cla8_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CLA8_OVF_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/cla8_pipe.sv
// rtl/cla8_pipe.sv - two-stage pipelined carry-lookahead adder, 4-bit groups; optional signed overflow via CLA8_OVF_EN
module cla8_pipe #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  cla8_pipe_if.slave   io
);
  localparam int NG = WIDTH / 4;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_g_q, s1_p_q;
  logic [NG:0]      s1_gc_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_sum_q;
  logic             s2_cout_q;

  logic [WIDTH-1:0] s1_g_d, s1_p_d;
  logic [NG:0]      s1_gc_d;
  logic [NG-1:0]    grp_g, grp_p;
  logic [WIDTH-1:0] s2_sum_d;
  logic             s2_cout_d;
  logic             s1_adv, s2_adv;

`ifdef CLA8_OVF_EN
  logic s1_amsb_q, s1_bmsb_q;
  logic s2_ovf_q, s2_ovf_d;
`endif

  // Flow control: a stage advances when it is empty or its successor advances
  assign s2_adv      = !s2_valid_q | io.out_ready;
  assign s1_adv      = !s1_valid_q | s2_adv;
  assign io.in_ready = s1_adv;

  // Stage 1 next state: bit g/p, group g/p, and lookahead group carries from cin
  always_comb begin : p_s1
    logic c_v, t_v;
    c_v     = 1'b0;
    t_v     = 1'b0;
    s1_g_d  = io.in_a & io.in_b;
    s1_p_d  = io.in_a ^ io.in_b;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &s1_p_d[4*k +: 4];
      grp_g[k] = s1_g_d[4*k+3]
               | (s1_p_d[4*k+3] & s1_g_d[4*k+2])
               | (s1_p_d[4*k+3] & s1_p_d[4*k+2] & s1_g_d[4*k+1])
               | (s1_p_d[4*k+3] & s1_p_d[4*k+2] & s1_p_d[4*k+1] & s1_g_d[4*k]);
    end
    s1_gc_d[0] = io.in_cin;
    // Fully expanded lookahead: every carry is a flat sum of products of group terms and cin
    for (int k = 0; k < NG; k++) begin
      c_v = io.in_cin;
      for (int m = 0; m <= k; m++) c_v = c_v & grp_p[m];
      for (int j = 0; j <= k; j++) begin
        t_v = grp_g[j];
        for (int m = j + 1; m <= k; m++) t_v = t_v & grp_p[m];
        c_v = c_v | t_v;
      end
      s1_gc_d[k+1] = c_v;
    end
  end

  // Stage 2 next state: in-group lookahead from the registered group carry-in, then sum
  always_comb begin : p_s2
    logic c_v, t_v;
    c_v      = 1'b0;
    t_v      = 1'b0;
    s2_sum_d = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        c_v = s1_gc_q[k];
        for (int m = 0; m < i; m++) c_v = c_v & s1_p_q[4*k+m];
        for (int j = 0; j < i; j++) begin
          t_v = s1_g_q[4*k+j];
          for (int m = j + 1; m < i; m++) t_v = t_v & s1_p_q[4*k+m];
          c_v = c_v | t_v;
        end
        s2_sum_d[4*k+i] = s1_p_q[4*k+i] ^ c_v;
      end
    end
    s2_cout_d = s1_gc_q[NG];
`ifdef CLA8_OVF_EN
    s2_ovf_d  = (s1_amsb_q == s1_bmsb_q) & (s2_sum_d[WIDTH-1] != s1_amsb_q);
`endif
  end

  // Stage 1 registers: load only on an input transfer so idle X never propagates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_gc_q    <= '0;
`ifdef CLA8_OVF_EN
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid_q <= io.in_valid;
      if (io.in_valid) begin
        s1_g_q    <= s1_g_d;
        s1_p_q    <= s1_p_d;
        s1_gc_q   <= s1_gc_d;
`ifdef CLA8_OVF_EN
        s1_amsb_q <= io.in_a[WIDTH-1];
        s1_bmsb_q <= io.in_b[WIDTH-1];
`endif
      end
    end
  end

  // Stage 2 registers: hold the result steady until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
`ifdef CLA8_OVF_EN
      s2_ovf_q   <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q  <= s2_sum_d;
        s2_cout_q <= s2_cout_d;
`ifdef CLA8_OVF_EN
        s2_ovf_q  <= s2_ovf_d;
`endif
      end
    end
  end

  assign io.out_valid = s2_valid_q;
  assign io.out_sum   = s2_sum_q;
  assign io.out_cout  = s2_cout_q;
`ifdef CLA8_OVF_EN
  assign io.out_ovf   = s2_ovf_q;
`endif

endmodule

// File: tb/tb_cla8_pipe.sv
// tb/tb_cla8_pipe.sv - directed and randomized self-checking bench for cla8_pipe
module tb_cla8_pipe;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cla8_pipe_if #(.WIDTH(8)) bus ();

  cla8_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_out_sum got=%h exp=00", bus.out_sum); end
    n_checks++; if (bus.out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b exp=0", bus.out_cout); end
`ifdef CLA8_OVF_EN
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_carry_ripple();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'h01; bus.in_cin = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_early_valid got=%b exp=0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ripple_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_sum !== 8'h00) begin n_fail++; $display("FAIL ripple_sum got=%h exp=00", bus.out_sum); end
    n_checks++; if (bus.out_cout !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", bus.out_cout); end
`ifdef CLA8_OVF_EN
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL ripple_ovf got=%b exp=0", bus.out_ovf); end
`endif
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic       eo [4];
    va = '{8'h0F, 8'h80, 8'h55, 8'h7F};
    vb = '{8'h01, 8'h80, 8'hAA, 8'h01};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    es = '{8'h10, 8'h00, 8'h00, 8'h80};
    ec = '{1'b0, 1'b1, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.in_valid = 1'b1; bus.in_a = va[i]; bus.in_b = vb[i]; bus.in_cin = vc[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, bus.out_valid); end
        n_checks++; if ({bus.out_cout, bus.out_sum} !== {ec[i-1], es[i-1]}) begin
          n_fail++; $display("FAIL b2b_result[%0d] got=%b/%h exp=%b/%h", i-1, bus.out_cout, bus.out_sum, ec[i-1], es[i-1]);
        end
`ifdef CLA8_OVF_EN
        n_checks++; if (bus.out_ovf !== eo[i-1]) begin n_fail++; $display("FAIL b2b_ovf[%0d] got=%b exp=%b", i-1, bus.out_ovf, eo[i-1]); end
`endif
      end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 8'h01; bus.in_b = 8'h01; bus.in_cin = 1'b0;
    tick();
    bus.in_a = 8'h02; bus.in_b = 8'h02;
    tick();
    bus.in_a = 8'h03; bus.in_b = 8'h03;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h02) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/02", i, bus.out_valid, bus.out_sum);
      end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h04) begin
      n_fail++; $display("FAIL bp_release got=%b/%h exp=1/04", bus.out_valid, bus.out_sum);
    end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_bubble();
    logic       iv [5];
    logic       ev [5];
    logic [7:0] es [5];
    iv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    es = '{8'h00, 8'h30, 8'h00, 8'h77, 8'h00};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = iv[i];
      if (i == 0) begin bus.in_a = 8'h10; bus.in_b = 8'h20; bus.in_cin = 1'b0; end
      if (i == 2) begin bus.in_a = 8'h33; bus.in_b = 8'h44; bus.in_cin = 1'b0; end
      tick();
      n_checks++; if (bus.out_valid !== ev[i]) begin n_fail++; $display("FAIL bubble_valid[%0d] got=%b exp=%b", i, bus.out_valid, ev[i]); end
      if (ev[i]) begin
        n_checks++; if (bus.out_sum !== es[i]) begin n_fail++; $display("FAIL bubble_sum[%0d] got=%h exp=%h", i, bus.out_sum, es[i]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 8'h11; bus.in_b = 8'h22; bus.in_cin = 1'b0;
    tick();
    bus.in_a = 8'h33; bus.in_b = 8'h44;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h33) begin
      n_fail++; $display("FAIL mid_full got=%b/%h exp=1/33", bus.out_valid, bus.out_sum);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00) begin
      n_fail++; $display("FAIL mid_async_clear got=%b/%h exp=0/00", bus.out_valid, bus.out_sum);
    end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost[%0d] got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_q [$];
    logic [9:0] e;
    logic [8:0] full;
    int sent;
    int got;
    int cycles;
    sent = 0; got = 0; cycles = 0;
    while ((sent < 10000 || exp_q.size() != 0) && cycles < 60000) begin
      if (sent < 10000) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_cin = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra got=%b/%h exp=none", bus.out_cout, bus.out_sum);
        end else begin
          e = exp_q.pop_front();
`ifdef CLA8_OVF_EN
          if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== e) begin
            n_fail++; $display("FAIL rand_result[%0d] got=%h exp=%h", got, {bus.out_ovf, bus.out_cout, bus.out_sum}, e);
          end
`else
          if ({bus.out_cout, bus.out_sum} !== e[8:0]) begin
            n_fail++; $display("FAIL rand_result[%0d] got=%h exp=%h", got, {bus.out_cout, bus.out_sum}, e[8:0]);
          end
`endif
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        full = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {8'h00, bus.in_cin};
        e = {(bus.in_a[7] == bus.in_b[7]) && (full[7] != bus.in_a[7]), full};
        exp_q.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    n_checks++;
    if (got != 10000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_count got=%0d pending=%0d exp=10000/0", got, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
